// File: rtl/jesd_tx_pkg.sv
// Shared types and constants for the JESD TX input buffer.
package jesd_tx_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StFill = 2'd2,
    StRun  = 2'd3
  } state_e;

  localparam int unsigned SAMPLE_W         = 16;
  localparam int unsigned DATA_W_DEFAULT   = 512;
  localparam int unsigned SAMPLES_PER_WORD = DATA_W_DEFAULT / SAMPLE_W;

  // Samples carried by one link word of the given width.
  function automatic int unsigned samples_per_word(input int unsigned data_w);
    return data_w / SAMPLE_W;
  endfunction

endpackage

// File: rtl/jesd_tx_sfifo.sv
// Synchronous FIFO with a registered read port and an occupancy output.
// rd_data only updates on a pop, and is zeroed by flush, so it can drive a
// link-facing data register directly.
module jesd_tx_sfifo #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_go, rd_go;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign wr_go   = wr_en && !full;
  assign rd_go   = rd_en && !empty;
  assign level   = level_q;
  assign rd_data = rd_data_q;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(wr_go);
      rptr_q  <= rptr_q + AW'(rd_go);
      level_q <= level_q + LVL_W'(wr_go) - LVL_W'(rd_go);
    end
  end

  // Storage array, no reset needed: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wptr_q] <= wr_data;
    end
  end

  // Registered read port; cleared on flush so stale data never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (flush) begin
      rd_data_q <= '0;
    end else if (rd_go) begin
      rd_data_q <= mem[rptr_q];
    end
  end

endmodule

// File: rtl/jesd_tx_din_buffer.sv
// Elastic buffer between user DAC samples and the JESD TX link layer.
// Aligns on din_sync, prefills, then streams continuously; an empty FIFO while
// running is an underflow that re-arms the buffer.
// Optional ramp test pattern enabled by defining JESD_TX_DIN_TESTPAT_EN.
module jesd_tx_din_buffer
  import jesd_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PREFILL = 8
) (
  input  logic                   link_clk,
  input  logic                   link_aresetn,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_vld,
  input  logic                   din_sync,
  output logic                   din_rdy,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   clr_status,
  input  logic                   tx_testpat,
  output logic                   din_overflow,
  output logic                   din_underflow,
  output logic [15:0]            underflow_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [1:0]             state
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              fifo_wr, fifo_rd, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  level;
  logic              wr_ok, ovf_evt, uf_evt, pat_active;
  logic              ovf_q, uf_q;
  logic [15:0]       uf_cnt_q;

  assign din_rdy       = !fifo_full && (state_q != StIdle);
  assign wr_ok         = din_vld && din_rdy;
  assign ovf_evt       = din_vld && fifo_full;
  assign tx_valid      = (state_q == StRun);
  assign state         = state_q;
  assign fifo_level    = level;
  assign din_overflow  = ovf_q;
  assign din_underflow = uf_q;
  assign underflow_cnt = uf_cnt_q;

  jesd_tx_sfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (link_clk),
    .rst_n   (link_aresetn),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (din),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register.
  always_ff @(posedge link_clk or negedge link_aresetn) begin
    if (!link_aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus FIFO write/read/flush strobes.
  always_comb begin
    state_d    = state_q;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    fifo_flush = 1'b0;
    uf_evt     = 1'b0;
    case (state_q)
      StIdle: state_d = StArm;
      StArm: begin
        // Unaligned words are accepted and thrown away until a sync word.
        if (wr_ok && din_sync) begin
          fifo_wr = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        fifo_wr = wr_ok;
        if (level >= LVL_W'(PREFILL)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        fifo_wr = wr_ok;
        if (tx_ready) begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
          end else if (!pat_active) begin
            uf_evt     = 1'b1;
            fifo_flush = 1'b1;
            state_d    = StArm;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky status flags and saturating underflow counter; events beat clears.
  always_ff @(posedge link_clk or negedge link_aresetn) begin
    if (!link_aresetn) begin
      ovf_q    <= 1'b0;
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      if (ovf_evt) begin
        ovf_q <= 1'b1;
      end else if (clr_status) begin
        ovf_q <= 1'b0;
      end
      if (uf_evt) begin
        uf_q <= 1'b1;
        if (clr_status) begin
          uf_cnt_q <= 16'd1;
        end else if (uf_cnt_q != 16'hFFFF) begin
          uf_cnt_q <= uf_cnt_q + 16'd1;
        end
      end else if (clr_status) begin
        uf_q     <= 1'b0;
        uf_cnt_q <= '0;
      end
    end
  end

`ifdef JESD_TX_DIN_TESTPAT_EN
  localparam int unsigned NSAMP = samples_per_word(DATA_W);

  logic [15:0]       base_q;
  logic              pat_q;
  logic [DATA_W-1:0] ramp_q, ramp_word;

  assign pat_active = tx_testpat && (state_q == StRun);
  assign tx_data    = pat_q ? ramp_q : fifo_rdata;

  // Ramp word for the current base: sample k = base + k.
  always_comb begin
    ramp_word = '0;
    for (int k = 0; k < int'(NSAMP); k++) begin
      ramp_word[k*SAMPLE_W +: SAMPLE_W] = base_q + 16'(k);
    end
  end

  // Ramp state only moves on accepted link cycles so tx_data holds otherwise.
  always_ff @(posedge link_clk or negedge link_aresetn) begin
    if (!link_aresetn) begin
      base_q <= '0;
      pat_q  <= 1'b0;
      ramp_q <= '0;
    end else if (state_q != StRun) begin
      base_q <= '0;
      pat_q  <= 1'b0;
      ramp_q <= '0;
    end else if (tx_ready) begin
      pat_q <= tx_testpat;
      if (tx_testpat) begin
        ramp_q <= ramp_word;
        base_q <= base_q + 16'(NSAMP);
      end
    end
  end
`else
  logic unused_testpat;
  assign unused_testpat = tx_testpat;
  assign pat_active     = 1'b0;
  assign tx_data        = fifo_rdata;
`endif

endmodule

// File: tb/tb_jesd_tx_din_buffer.sv
// Directed self-checking bench for jesd_tx_din_buffer (DATA_W=512, DEPTH=16,
// PREFILL=8). Inputs change 1 ns after the rising edge; outputs are checked
// at that point, well away from the next edge.
module tb_jesd_tx_din_buffer;

  localparam int unsigned DATA_W  = 512;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PREFILL = 8;

  logic              link_clk = 1'b0;
  logic              link_aresetn = 1'b0;
  logic [DATA_W-1:0] din;
  logic              din_vld, din_sync, din_rdy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_ready, clr_status, tx_testpat;
  logic              din_overflow, din_underflow;
  logic [15:0]       underflow_cnt;
  logic [4:0]        fifo_level;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;

  jesd_tx_din_buffer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .PREFILL (PREFILL)
  ) dut (
    .link_clk      (link_clk),
    .link_aresetn  (link_aresetn),
    .din           (din),
    .din_vld       (din_vld),
    .din_sync      (din_sync),
    .din_rdy       (din_rdy),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .clr_status    (clr_status),
    .tx_testpat    (tx_testpat),
    .din_overflow  (din_overflow),
    .din_underflow (din_underflow),
    .underflow_cnt (underflow_cnt),
    .fifo_level    (fifo_level),
    .state         (state)
  );

  always #5 link_clk = ~link_clk;

  // Distinct word per id: every 32-bit lane differs.
  function automatic logic [DATA_W-1:0] mk(input int id);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < 16; k++) begin
      w[k*32 +: 32] = 32'hA500_0000 + 32'(id) + (32'(k) << 16);
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] ramp(input int base);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < 32; k++) begin
      w[k*16 +: 16] = 16'(base + k);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge link_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    din = '0; din_vld = 0; din_sync = 0; tx_ready = 0; clr_status = 0; tx_testpat = 0;
    #3;
    // Reset state
    chk("rst_state", state, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", din_overflow, 0);
    chk("rst_uf", din_underflow, 0);
    chk("rst_cnt", underflow_cnt, 0);
    @(posedge link_clk); #1;
    link_aresetn = 1;
    chk("idle_after_release", state, 0);
    tick();
    chk("arm_state", state, 1);
    chk("arm_din_rdy", din_rdy, 1);

    // Basic flow: 8 words, sync first, link always ready
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      din = mk(i); din_vld = 1; din_sync = (i == 0);
      tick();
      if (i == 0) begin
        chk("fill_state", state, 2);
        chk("fill_tx_valid", tx_valid, 0);
        chk("fill_tx_data", tx_data, 0);
      end
    end
    din_vld = 0; din_sync = 0;
    chk("prefill_level", fifo_level, 8);
    chk("prefill_still_fill", state, 2);
    tick();
    chk("run_state", state, 3);
    chk("run_tx_valid", tx_valid, 1);
    chk("run_first_tx_data", tx_data, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t1_word%0d", i), tx_data, mk(i));
      chk("t1_tx_valid", tx_valid, 1);
    end
    chk("t1_drained_level", fifo_level, 0);
    tick();
    chk("uf_tx_data", tx_data, 0);
    chk("uf_flag", din_underflow, 1);
    chk("uf_cnt", underflow_cnt, 1);
    chk("uf_state_arm", state, 1);
    chk("uf_tx_valid", tx_valid, 0);
    clr_status = 1;
    tick();
    clr_status = 0;
    chk("clr_uf", din_underflow, 0);
    chk("clr_cnt", underflow_cnt, 0);

    // Alignment: unsynced words in ARM are discarded
    for (int i = 0; i < 3; i++) begin
      din = mk(100 + i); din_vld = 1; din_sync = 0;
      tick();
    end
    chk("t2_still_arm", state, 1);
    chk("t2_discard_level", fifo_level, 0);
    for (int i = 0; i < 8; i++) begin
      din = mk(103 + i); din_vld = 1; din_sync = (i == 0);
      tick();
    end
    din_vld = 0; din_sync = 0;
    tick();
    chk("t2_run", state, 3);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_word%0d", i), tx_data, mk(103 + i));
    end
    tick();
    chk("t2_uf_arm", state, 1);
    chk("t2_uf_cnt", underflow_cnt, 1);

    // Overflow: 20 words into a 16-deep FIFO with the link stalled
    tx_ready = 0;
    for (int i = 0; i < 20; i++) begin
      din = mk(200 + i); din_vld = 1; din_sync = (i == 0); clr_status = (i == 19);
      tick();
    end
    din_vld = 0; din_sync = 0;
    chk("ovf_level", fifo_level, 16);
    chk("ovf_din_rdy", din_rdy, 0);
    chk("ovf_flag_beats_clr", din_overflow, 1);
    chk("ovf_uf_cleared", din_underflow, 0);
    chk("ovf_cnt_cleared", underflow_cnt, 0);
    chk("ovf_state_run", state, 3);
    chk("ovf_tx_data_idle", tx_data, 0);
    tick();
    chk("ovf_clr_alone", din_overflow, 0);
    clr_status = 0;
    tx_ready = 1;
    tick();
    chk("t3_word0", tx_data, mk(200));
    tick();
    chk("t3_word1", tx_data, mk(201));
    chk("t3_level14", fifo_level, 14);
    din = mk(300); din_vld = 1;
    tick();
    chk("t3_word2", tx_data, mk(202));
    chk("t3_rw_level", fifo_level, 14);
    din = mk(301);
    tick();
    din_vld = 0;
    chk("t3_word3", tx_data, mk(203));
    chk("t3_rw_level2", fifo_level, 14);
    for (int i = 4; i < 16; i++) begin
      tick();
      chk($sformatf("t3_word%0d", i), tx_data, mk(200 + i));
    end
    tick();
    chk("t3_extra0", tx_data, mk(300));
    tick();
    chk("t3_extra1", tx_data, mk(301));
    tick();
    chk("t3_uf_tx_data", tx_data, 0);
    chk("t3_uf_flag", din_underflow, 1);
    chk("t3_uf_cnt", underflow_cnt, 1);
    chk("t3_uf_arm", state, 1);

    // Reset mid-RUN with 5 words buffered
    tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      din = mk(400 + i); din_vld = 1; din_sync = (i == 0);
      tick();
    end
    din_vld = 0; din_sync = 0;
    tick();
    tx_ready = 1;
    tick(); tick(); tick();
    chk("t4_pre_rst_data", tx_data, mk(402));
    chk("t4_pre_rst_level", fifo_level, 5);
    #2;
    link_aresetn = 0;
    #1;
    chk("t4_rst_state", state, 0);
    chk("t4_rst_tx_valid", tx_valid, 0);
    chk("t4_rst_tx_data", tx_data, 0);
    chk("t4_rst_din_rdy", din_rdy, 0);
    chk("t4_rst_level", fifo_level, 0);
    chk("t4_rst_uf", din_underflow, 0);
    chk("t4_rst_cnt", underflow_cnt, 0);
    @(posedge link_clk); #1;
    link_aresetn = 1;
    tick();
    chk("t4_arm", state, 1);
    for (int i = 0; i < 8; i++) begin
      din = mk(500 + i); din_vld = 1; din_sync = (i == 0);
      tick();
    end
    din_vld = 0; din_sync = 0;
    tick();
    chk("t4_run", state, 3);
    tick();
    chk("t4_no_stale0", tx_data, mk(500));
    tick();
    chk("t4_no_stale1", tx_data, mk(501));

`ifdef JESD_TX_DIN_TESTPAT_EN
    // Ramp test pattern
    link_aresetn = 0;
    #2;
    @(posedge link_clk); #1;
    link_aresetn = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      din = mk(600 + i); din_vld = 1; din_sync = (i == 0);
      tick();
    end
    din_vld = 0; din_sync = 0;
    tx_testpat = 1;
    tick();
    chk("tp_run", state, 3);
    tick();
    chk("tp_word0", tx_data, ramp(0));
    tick();
    chk("tp_word1", tx_data, ramp(32));
    chk("tp_no_uf", din_underflow, 0);
    repeat (10) tick();
    chk("tp_word11", tx_data, ramp(352));
    chk("tp_still_run", state, 3);
    chk("tp_drained", fifo_level, 0);
    chk("tp_no_uf_empty", din_underflow, 0);
    tx_testpat = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
